// File: rtl/lfsr_cipher_pkg.sv
// Shared definitions for the LFSR stream cipher (encrypt and decrypt sides).
// Keystream width, reload seed, feedback taps and receive FSM states.
package lfsr_cipher_pkg;

  localparam int LFSR_W = 16;

  localparam logic [0:LFSR_W-1] SEED = 16'b1010110011100001;

  localparam int TAP_A = 10;
  localparam int TAP_B = 12;
  localparam int TAP_C = 13;
  localparam int TAP_D = 15;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } rx_state_t;

  function automatic logic [0:LFSR_W-1] lfsr_next(
    input logic [0:LFSR_W-1] s
  );
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {fb, s[0:LFSR_W-2]};
  endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// Keystream generator: reloadable 16-bit LFSR, key bit taken before the step.
// Load has priority over step.
module lfsr_keystream
  import lfsr_cipher_pkg::*;
#(
  parameter logic [0:LFSR_W-1] SEED_VAL = SEED
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              load,
  input  logic              step,
  output logic              key_bit,
  output logic [0:LFSR_W-1] state
);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= SEED_VAL;
    end else if (load) begin
      state <= SEED_VAL;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

  assign key_bit = state[LFSR_W-1];

endmodule

// File: rtl/lfsr_decrypt_rx.sv
// Receive-side stream decryptor: strips the LFSR keystream from the
// serial link and delivers LSB-first bytes over valid/ready.
module lfsr_decrypt_rx
  import lfsr_cipher_pkg::*;
#(
  parameter logic [0:LFSR_W-1] SEED   = lfsr_cipher_pkg::SEED,
  parameter int                BYTE_W = 8
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              resync,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              overrun,
  output logic              locked
);

  localparam int CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

  rx_state_t state_q;
  rx_state_t state_d;

  logic [CNT_W-1:0]  count;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] next_word;
  logic              key_bit;
  logic              plain;
  logic              accept;
  logic              byte_done;
  logic              take;
  logic [0:LFSR_W-1] ks_state;

  lfsr_keystream #(
    .SEED_VAL (SEED)
  ) u_ks (
    .clock   (clock),
    .n_reset (n_reset),
    .load    (resync),
    .step    (accept),
    .key_bit (key_bit),
    .state   (ks_state)
  );

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == WAIT_SYNC): if (resync) state_d = RUN;
      (state_q == RUN):       state_d = RUN;
    endcase
  end

  always_comb begin
    locked = (state_q == RUN);
  end

  // resync beats a coincident bit; that bit never touches the keystream
  assign accept    = locked && bit_valid && !resync;
  assign plain     = bit_in ^ key_bit;
  assign byte_done = accept && (count == CNT_LAST);
  assign take      = !byte_valid || byte_ready;

  always_comb begin
    next_word        = shreg;
    next_word[count] = plain;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
      shreg <= '0;
    end else if (resync) begin
      count <= '0;
      shreg <= '0;
    end else if (accept) begin
      if (byte_done) begin
        count <= '0;
        shreg <= '0;
      end else begin
        count <= count + 1'b1;
        shreg <= next_word;
      end
    end
  end

  // Single-entry hold buffer; a byte arriving while full is dropped
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      byte_out   <= '0;
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (resync) begin
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (byte_done) begin
      if (take) begin
        byte_out   <= next_word;
        byte_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (byte_valid && byte_ready) begin
      byte_valid <= 1'b0;
    end
  end

endmodule

// File: doc/lfsr_decrypt_rx.md
# lfsr_decrypt_rx

- Receive-side counterpart of the keyboard LFSR stream encryptor.
- Takes the encrypted serial bitstream, regenerates the identical 16-bit keystream, XORs it off, and packs plaintext bits LSB-first into bytes.
- Each byte is delivered to the host-side logic over a valid/ready handshake.
- Sits between the serial link receiver and the USB HID report builder.

## Interface
Parameters:
- SEED, 16'b1010110011100001, keystream reload value (index order [0:15], bit 0 leftmost).
- BYTE_W, 8, bits per output word.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- n_reset  in  1  asynchronous, active-low reset.
- resync  in  1  one-cycle pulse: reload SEED and start/restart byte framing.
- bit_in  in  1  encrypted serial bit.
- bit_valid  in  1  bit_in qualifier; one keystream step per accepted bit.
- byte_out  out  BYTE_W  decrypted byte.
- byte_valid  out  1  byte_out holds an unconsumed byte.
- byte_ready  in  1  consumer accepts byte_out when byte_valid && byte_ready.
- overrun  out  1  sticky: a completed byte was dropped; cleared only by resync or reset.
- locked  out  1  high in RUN state.

## Operation
- Keystream register lfsr[0:15]:
  - feedback = lfsr[10]^lfsr[12]^lfsr[13]^lfsr[15]
  - step: lfsr <= {feedback, lfsr[0:14]}
  - key bit = lfsr[15], sampled before the step.
- Plaintext bit = bit_in ^ lfsr[15].
- FSM states WAIT_SYNC, RUN.
- WAIT_SYNC (reset state):
  - bit_valid ignored; lfsr holds SEED.
  - resync -> RUN: lfsr <= SEED, bit counter <= 0, shift register cleared.
- RUN:
  - Each bit_valid: decrypt, shift into assembly register at position count (LSB first), step lfsr, count++.
  - On count 7 -> 0 wrap: byte complete.
  - resync in RUN: same reload as above; partial byte discarded; stays RUN.
- Output holding register (single entry):
  - Byte completes with byte_valid=0, or with byte_valid=1 && byte_ready=1 in the same cycle: load byte_out, byte_valid=1.
  - Byte completes with byte_valid=1 && byte_ready=0: new byte dropped, held byte kept, overrun<=1. Keystream and count still advance, so alignment is preserved.
  - Handshake completes with no new byte: byte_valid<=0.
- resync && bit_valid in the same cycle: resync wins; the bit is discarded and is not consumed as keystream.
- resync clears overrun and byte_valid. A pending byte is lost.

## Timing
- Reset values: byte_out=0, byte_valid=0, overrun=0, locked=0, lfsr=SEED, count=0, state=WAIT_SYNC.
- Reset mid-byte aborts immediately (asynchronous).
- Latency: byte_valid rises on the posedge after the cycle carrying the 8th bit's bit_valid.
- byte_out is stable while byte_valid && !byte_ready.
- Back-to-back bit_valid every cycle is supported. Throughput is 1 byte / 8 cycles with byte_ready held high, with no drops.
- locked rises the cycle after resync is sampled in WAIT_SYNC.

## Structure
- Package lfsr_cipher_pkg holds:
  - LFSR_W=16, SEED, tap indices {10,12,13,15}
  - rx_state_t enum {WAIT_SYNC, RUN}
  - function lfsr_next(logic [0:15]) returning the stepped state
- The encryptor shares this package.
- Sub-module lfsr_keystream (load, step, key_bit, state) is the natural split; it is reused by the encryptor side.
- Top level holds the FSM, bit counter, assembly register, and output buffer.

## Test plan
- Reset, resync, then 8 bits of 0 (LSB first) -> byte_out=0xE1, byte_valid=1 one cycle after the 8th bit.
- Resync, then ciphertext 0xA0 followed by 0xAC -> bytes 0x41 then 0x00. This checks keystream continuity into byte 2 (k8..k15 = 0xAC).
- Bits with bit_valid before any resync -> no byte_valid, lfsr unchanged, locked=0.
- Hold byte_ready=0 across two full bytes -> first byte retained, overrun=1. A third byte after the handshake decrypts correctly, confirming alignment kept.
- Resync after 5 bits of a byte, then 0x00 ciphertext -> byte_out=0xE1, partial bits discarded, overrun cleared.
- Assert n_reset low mid-byte, then resync -> all outputs at reset values; next byte decrypts with keystream restarted from SEED.
